// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and default constants for the FIFO drain arbiter and its
// round-robin selector.
package fifo_drain_arbiter_pkg;

  localparam int DefNumReq       = 32'sd4;
  localparam int DefReqBitWidth  = 32'sd2;
  localparam int DefSplitWidth   = 32'sd32;
  localparam int DefBurstLen     = 32'sd8;
  localparam int DefBurstBitWidth = 32'sd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drainState_t;

endpackage

// File: rtl/fifo_drain_arbiter_rr.sv
// Combinational round-robin picker: first set request bit strictly after
// lastGrant, wrapping from NUM_REQ-1 back to 0.
module rr_priority_select
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DefNumReq,
  parameter int REQ_BIT_WIDTH = DefReqBitWidth
) (
  input  logic [NUM_REQ-1:0]       request,
  input  logic [REQ_BIT_WIDTH-1:0] lastGrant,
  output logic                     found,
  output logic [REQ_BIT_WIDTH-1:0] index
);

  // Walk the ring starting one past the previous winner; the first hit wins.
  always_comb begin
    int cand;
    logic [REQ_BIT_WIDTH-1:0] candIdx;
    found   = 1'b0;
    index   = '0;
    cand    = 32'sd0;
    candIdx = '0;
    for (int k = 32'sd1; k <= NUM_REQ; k++) begin
      cand = int'(lastGrant) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      candIdx = REQ_BIT_WIDTH'(cand);
      if (!found && request[candIdx]) begin
        found = 1'b1;
        index = candIdx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains fixed-length bursts from several show-ahead FIFOs into one downstream
// port, granting requesters round-robin and holding a grant for a full burst.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = DefNumReq,
  parameter int REQ_BIT_WIDTH   = DefReqBitWidth,
  parameter int SPLIT_WIDTH     = DefSplitWidth,
  parameter int BURST_LEN       = DefBurstLen,
  parameter int BURST_BIT_WIDTH = DefBurstBitWidth
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic [NUM_REQ-1:0]             fifoEmpty,
  input  logic [NUM_REQ*SPLIT_WIDTH-1:0] fifoData,
  output logic [NUM_REQ-1:0]             fifoRead,
  input  logic                           downFull,
  output logic                           outValid,
  output logic [SPLIT_WIDTH-1:0]         outData,
  output logic [REQ_BIT_WIDTH-1:0]       outSource,
  output logic                           busy
);

  localparam logic [BURST_BIT_WIDTH-1:0] LastBeat       = BURST_BIT_WIDTH'(BURST_LEN - 32'sd1);
  localparam logic [REQ_BIT_WIDTH-1:0]   ResetLastGrant = REQ_BIT_WIDTH'(NUM_REQ - 32'sd1);
  localparam logic [BURST_BIT_WIDTH-1:0] CountOne       = {{(BURST_BIT_WIDTH-1){1'b0}}, 1'b1};

  drainState_t                stateR, stateNextS;
  logic [REQ_BIT_WIDTH-1:0]   grantR, grantNextS;
  logic [REQ_BIT_WIDTH-1:0]   lastGrantR, lastGrantNextS;
  logic [BURST_BIT_WIDTH-1:0] countR, countNextS;
  logic                       foundS;
  logic [REQ_BIT_WIDTH-1:0]   pickS;
  logic                       readS;
  logic [SPLIT_WIDTH-1:0]     grantDataS;

  rr_priority_select #(
    .NUM_REQ       (NUM_REQ),
    .REQ_BIT_WIDTH (REQ_BIT_WIDTH)
  ) uRrSelect (
    .request   (~fifoEmpty),
    .lastGrant (lastGrantR),
    .found     (foundS),
    .index     (pickS)
  );

  assign readS = (stateR == BURST) & ~downFull & ~fifoEmpty[grantR];
  assign busy  = (stateR == BURST);

  // Select the granted requester's word out of the flat data bus.
  always_comb begin
    grantDataS = '0;
    for (int i = 32'sd0; i < NUM_REQ; i++) begin
      if (grantR == REQ_BIT_WIDTH'(i)) begin
        grantDataS = fifoData[i*SPLIT_WIDTH +: SPLIT_WIDTH];
      end else begin
        grantDataS = grantDataS;
      end
    end
  end

  // Next-state, grant bookkeeping and the read strobe.
  always_comb begin
    stateNextS     = stateR;
    grantNextS     = grantR;
    lastGrantNextS = lastGrantR;
    countNextS     = countR;
    fifoRead       = '0;
    case (stateR)
      IDLE: begin
        if (foundS) begin
          stateNextS = BURST;
          grantNextS = pickS;
          countNextS = '0;
        end else begin
          stateNextS = IDLE;
        end
      end
      BURST: begin
        if (readS) begin
          fifoRead[grantR] = 1'b1;
          countNextS       = countR + CountOne;
          if (countR == LastBeat) begin
            stateNextS     = IDLE;
            lastGrantNextS = grantR;
          end else begin
            stateNextS = BURST;
          end
        end else begin
          stateNextS = BURST;
        end
      end
      default: begin
        stateNextS = IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stateR     <= IDLE;
      grantR     <= '0;
      lastGrantR <= ResetLastGrant;
      countR     <= '0;
    end else begin
      stateR     <= stateNextS;
      grantR     <= grantNextS;
      lastGrantR <= lastGrantNextS;
      countR     <= countNextS;
    end
  end

  // Output stage: one-cycle latency, data and source held between reads.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      outValid  <= 1'b0;
      outData   <= '0;
      outSource <= '0;
    end else if (readS) begin
      outValid  <= 1'b1;
      outData   <= grantDataS;
      outSource <= grantR;
    end else begin
      outValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Randomized bench for fifo_drain_arbiter against a burst-level reference model
// that owns the upstream FIFO contents as queues.
module tb_fifo_drain_arbiter;

  localparam int NR = 4;
  localparam int SW = 32;
  localparam int BL = 8;

  logic             clk;
  logic             rstb;
  logic [NR-1:0]    fifoEmpty;
  logic [NR*SW-1:0] fifoData;
  logic [NR-1:0]    fifoRead;
  logic             downFull;
  logic             outValid;
  logic [SW-1:0]    outData;
  logic [1:0]       outSource;
  logic             busy;

  fifo_drain_arbiter #(
    .NUM_REQ(NR), .REQ_BIT_WIDTH(2), .SPLIT_WIDTH(SW), .BURST_LEN(BL), .BURST_BIT_WIDTH(3)
  ) dut (
    .clk(clk), .rstb(rstb), .fifoEmpty(fifoEmpty), .fifoData(fifoData), .fifoRead(fifoRead),
    .downFull(downFull), .outValid(outValid), .outData(outData), .outSource(outSource), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0] fq [NR][$];

  // Model: owner of the current burst (-1 while arbitrating) and words left.
  int mOwner, mRem, mLast, mBurstReads;
  logic          expValid;
  logic [SW-1:0] expData;
  logic [1:0]    expSrc;

  int checks, errors;
  int rdCount, vldCount;
  int stallLeft, refill, total;
  logic df;
  logic hit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic load(input int idx, input int n, input logic [SW-1:0] base);
    for (int j = 0; j < n; j++) fq[idx].push_back(base + 32'(j));
  endtask

  task automatic step(input logic dfIn);
    logic [NR-1:0] expRead;
    logic          expBusy, nValid;
    logic [SW-1:0] nData;
    logic [1:0]    nSrc;
    int            pick, c;
    @(negedge clk);
    downFull = dfIn;
    for (int i = 0; i < NR; i++) begin
      fifoEmpty[i] = (fq[i].size() == 0);
      fifoData[i*SW +: SW] = (fq[i].size() == 0) ? 32'hDEAD_0000 + 32'(i) : fq[i][0];
    end
    #1;
    expRead = '0;
    expBusy = (mOwner >= 0);
    nValid  = 1'b0;
    nData   = expData;
    nSrc    = expSrc;
    if (mOwner < 0) begin
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (mLast + k) % NR;
        if (pick < 0 && fq[c].size() > 0) pick = c;
      end
      if (pick >= 0) begin
        mOwner = pick;
        mRem = BL;
        mBurstReads = 0;
      end
    end else if (!dfIn && fq[mOwner].size() > 0) begin
      expRead[mOwner] = 1'b1;
      nValid = 1'b1;
      nData  = fq[mOwner].pop_front();
      nSrc   = 2'(mOwner);
      mRem--;
      mBurstReads++;
      if (mRem == 0) begin
        mLast  = mOwner;
        mOwner = -1;
      end
    end
    chk("fifoRead", 64'(fifoRead), 64'(expRead));
    chk("busy", 64'(busy), 64'(expBusy));
    chk("outValid", 64'(outValid), 64'(expValid));
    chk("outData", 64'(outData), 64'(expData));
    chk("outSource", 64'(outSource), 64'(expSrc));
    if (|fifoRead) rdCount++;
    if (outValid) vldCount++;
    expValid = nValid;
    expData  = nData;
    expSrc   = nSrc;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstb = 1'b0;
    fifoEmpty = '1;
    downFull = 1'b1;
    #1;
    chk("rstOutValid", 64'(outValid), 64'd0);
    chk("rstOutData", 64'(outData), 64'd0);
    chk("rstOutSource", 64'(outSource), 64'd0);
    chk("rstFifoRead", 64'(fifoRead), 64'd0);
    chk("rstBusy", 64'(busy), 64'd0);
    mOwner = -1; mRem = 0; mLast = NR - 1; mBurstReads = 0;
    expValid = 1'b0; expData = '0; expSrc = '0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rstb = 1'b0; fifoEmpty = '1; fifoData = '0; downFull = 1'b0;
    doReset();

    // Single requester 2, eight words.
    load(2, 8, 32'hD000_0000);
    rdCount = 0; vldCount = 0;
    repeat (12) step(1'b0);
    chk("s1Reads", 64'(rdCount), 64'd8);
    chk("s1Valid", 64'(vldCount), 64'd8);

    // All four full: 4 bursts in 36 cycles.
    doReset();
    for (int i = 0; i < NR; i++) load(i, 8, 32'h1000_0000 * 32'(i + 1));
    rdCount = 0; vldCount = 0;
    repeat (36) step(1'b0);
    chk("s2Reads", 64'(rdCount), 64'd32);
    total = 0;
    for (int i = 0; i < NR; i++) total += fq[i].size();
    chk("s2Drained", 64'(total), 64'd0);
    step(1'b0);
    chk("s2Valid", 64'(vldCount), 64'd32);

    // Backpressure for three cycles after the fourth read.
    load(1, 8, 32'hB000_0000);
    stallLeft = 3; rdCount = 0;
    repeat (16) begin
      df = (mOwner >= 0 && mBurstReads == 4 && stallLeft > 0);
      if (df) stallLeft--;
      step(df);
    end
    chk("s3Reads", 64'(rdCount), 64'd8);

    // Granted FIFO runs dry after five words, refills later.
    load(2, 5, 32'hC000_0000);
    load(3, 8, 32'hC300_0000);
    refill = -1; rdCount = 0;
    repeat (40) begin
      if (refill < 0 && mOwner == 2 && mBurstReads == 5) refill = 4;
      if (refill > 0) begin
        refill--;
        if (refill == 0) begin
          load(2, 3, 32'hC000_0005);
          refill = -2;
        end
      end
      step(1'b0);
    end
    chk("s4Reads", 64'(rdCount), 64'd16);

    // Idle stretch: nothing to drain.
    rdCount = 0;
    repeat (20) step(1'b0);
    chk("s6Reads", 64'(rdCount), 64'd0);

    // Reset after the third read of a burst.
    load(0, 8, 32'hE000_0000);
    load(1, 8, 32'hE100_0000);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      step(1'b0);
      if (mOwner >= 0 && mBurstReads == 3) hit = 1'b1;
    end
    chk("s5Reached", 64'(hit), 64'd1);
    doReset();
    repeat (30) step(1'b0);

    // Randomized traffic.
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        r = int'($urandom_range(0, NR - 1));
        if (fq[r].size() < 16) load(r, int'($urandom_range(1, 4)), $urandom);
      end
      if ($urandom_range(0, 499) == 0) doReset();
      step($urandom_range(0, 3) == 0);
    end
    repeat (100) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
